// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg
// Shared uart globals: data width, drain FSM state encoding and the
// default FIFO depth / busy-timeout used by uart_tx_feeder.
// No ports (package).

package uart_tx_feeder_pkg;

  localparam int NUM_DATA_BITS = 8;

  localparam int FEED_DEPTH   = 16;
  localparam int FEED_TIMEOUT = 4;

  localparam logic [1:0] FEED_IDLE       = 2'd0;
  localparam logic [1:0] FEED_ISSUE      = 2'd1;
  localparam logic [1:0] FEED_WAIT_START = 2'd2;
  localparam logic [1:0] FEED_WAIT_DONE  = 2'd3;

endpackage

// File: rtl/uart_tx_feeder_fifo.sv
// sync_fifo
// Single-clock FIFO with push/pop/flush and registered count/full/empty.
// Pushes are ignored when full, pops ignored when empty, and flush wins
// over both (pointers and count return to zero next cycle).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write strobe and data
//   pop, pop_data       read strobe and head-of-queue data (combinational)
//   flush               discard everything queued
//   count, full, empty  occupancy, registered

module sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH  = FEED_DEPTH,
  parameter int DATA_W = NUM_DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_next;
  logic              do_push;
  logic              do_pop;

  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (do_push && !do_pop) begin
      count_next = count + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_ONE;
    end
  end

  // Storage is deliberately left out of reset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Queues bytes in a FIFO and feeds them one at a time to a downstream
// uart_tx, pulsing tx_write and then waiting for the transmitter to go
// busy and report done. A transmitter that never goes busy is flagged
// through the sticky fault output and the byte is dropped.
// Ports:
//   clk, rst          single clock shared with uart_tx, sync active-high reset
//   en                block enable (also drives tx_enable, one cycle late)
//   flush             discard all queued bytes
//   wr, wr_data       push strobe and byte
//   full, empty,count FIFO status
//   overflow          sticky: a push was dropped because the FIFO was full
//   fault             sticky: tx_busy failed to rise within TIMEOUT cycles
//   tx_enable, tx_write, tx_data   to uart_tx
//   tx_busy, tx_done  from uart_tx
//   drain_busy        high while a byte is in flight

module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH   = FEED_DEPTH,
  parameter int DATA_W  = NUM_DATA_BITS,
  parameter int TIMEOUT = FEED_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   wr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   fault,
  output logic                   tx_enable,
  output logic                   tx_write,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   drain_busy
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  logic [1:0]        state;
  logic [TW-1:0]     timer;
  logic [DATA_W-1:0] head_data;
  logic              issue;

  // A flush in the same cycle as a would-be issue wins, so the FIFO never
  // sees pop and flush together.
  assign issue = (state == FEED_IDLE) && en && !empty && !tx_busy && !flush;

  assign drain_busy = (state != FEED_IDLE);

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr),
    .push_data (wr_data),
    .pop       (issue),
    .pop_data  (head_data),
    .flush     (flush),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Drop detection uses the registered full flag, so a pop in the same
  // cycle does not rescue the byte. A push swallowed by flush is not an
  // overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      tx_enable <= 1'b0;
    end else begin
      tx_enable <= en;
      if (wr && full && !flush) begin
        overflow <= 1'b1;
      end
    end
  end

  // Drain FSM. Dropping en parks it in IDLE immediately; whatever byte was
  // in flight is abandoned since tx_enable low resets the transmitter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FEED_IDLE;
      timer    <= '0;
      tx_write <= 1'b0;
      tx_data  <= '0;
      fault    <= 1'b0;
    end else if (!en) begin
      state    <= FEED_IDLE;
      tx_write <= 1'b0;
    end else begin
      case (state)
        FEED_IDLE: begin
          if (issue) begin
            tx_data  <= head_data;
            tx_write <= 1'b1;
            state    <= FEED_ISSUE;
          end
        end
        FEED_ISSUE: begin
          tx_write <= 1'b0;
          timer    <= '0;
          state    <= FEED_WAIT_START;
        end
        FEED_WAIT_START: begin
          if (tx_busy) begin
            state <= FEED_WAIT_DONE;
          end else if (timer == TIMER_LAST) begin
            fault <= 1'b1;
            state <= FEED_IDLE;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        FEED_WAIT_DONE: begin
          if (tx_done) begin
            state <= FEED_IDLE;
          end
        end
        default: begin
          state <= FEED_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
// Self-checking bench for uart_tx_feeder. A small behavioural uart_tx
// serialises each written byte LSB-first (start, 8 data, stop, one bit per
// clock) and reassembles the frame into rx_q; expected bytes go into exp_q
// as they are pushed. Each scenario task compares the two queues and the
// status outputs inline.

module tb_uart_tx_feeder;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       fault;
  logic       tx_enable;
  logic       tx_write;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       drain_busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  // uart_tx model state
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [9:0] m_sh = 10'h3FF;
  logic [9:0] m_rx = 10'h000;
  int         m_bits = 0;
  logic       stuck_busy = 1'b0;
  int         frame_err = 0;
  int         pulses = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH   (DEPTH),
    .DATA_W  (8),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .wr         (wr),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .fault      (fault),
    .tx_enable  (tx_enable),
    .tx_write   (tx_write),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .drain_busy (drain_busy)
  );

  assign tx_busy = m_busy;
  assign tx_done = m_done;

  // Behavioural transmitter: frame = {stop, data, start}, shifted out LSB
  // first; m_rx collects the bits as they leave.
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (!tx_enable) begin
      m_busy <= 1'b0;
      m_bits <= 0;
    end else if (!m_busy) begin
      if (tx_write && !stuck_busy) begin
        m_busy <= 1'b1;
        m_sh   <= {1'b1, tx_data, 1'b0};
        m_bits <= 0;
      end
    end else begin
      m_rx   <= {m_sh[0], m_rx[9:1]};
      m_sh   <= {1'b1, m_sh[9:1]};
      m_bits <= m_bits + 1;
      if (m_bits == 9) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        rx_q.push_back(m_rx[9:2]);
        if (m_rx[1] !== 1'b0 || m_sh[0] !== 1'b1) frame_err <= frame_err + 1;
      end
    end
  end

  // Counts tx_write pulses (sampled at the edge that follows each pulse).
  always @(posedge clk) begin
    if (tx_write === 1'b1) pulses <= pulses + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish required finish before 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    wr = 1'b0;
    flush = 1'b0;
    stuck_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rx_q.delete();
    frame_err = 0;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit keep);
    wr = 1'b1;
    wr_data = d;
    if (keep) exp_q.push_back(d);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (count !== 5'd0)     begin miscompares++; $display("[TB] FAIL reset_count: got %0d required 0", count); end
    vectors++; if (empty !== 1'b1)     begin miscompares++; $display("[TB] FAIL reset_empty: got %b required 1", empty); end
    vectors++; if (full !== 1'b0)      begin miscompares++; $display("[TB] FAIL reset_full: got %b required 0", full); end
    vectors++; if (overflow !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_overflow: got %b required 0", overflow); end
    vectors++; if (fault !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_fault: got %b required 0", fault); end
    vectors++; if (tx_write !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_tx_write: got %b required 0", tx_write); end
    vectors++; if (tx_data !== 8'h00)  begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h required 00", tx_data); end
    vectors++; if (tx_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_enable: got %b required 0", tx_enable); end
    vectors++; if (drain_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_drain_busy: got %b required 0", drain_busy); end
  endtask

  task automatic test_two_bytes();
    int base;
    int guard;
    logic [7:0] e;
    logic [7:0] g;
    do_reset();
    en = 1'b1;
    base = pulses;
    push_byte(8'hA5, 1'b1);
    push_byte(8'h3C, 1'b1);
    guard = 0;
    while (rx_q.size() < 2 && guard < 200) begin @(negedge clk); guard++; end
    vectors++;
    if (rx_q.size() < 2) begin miscompares++; $display("[TB] FAIL two_bytes_frames: got %0d frames required 2", rx_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) g = rx_q.pop_front(); else g = 'x;
      vectors++;
      if (g !== e) begin miscompares++; $display("[TB] FAIL two_bytes_data: got %h required %h", g, e); end
    end
    guard = 0;
    while ((drain_busy || !empty) && guard < 50) begin @(negedge clk); guard++; end
    vectors++; if (empty !== 1'b1)      begin miscompares++; $display("[TB] FAIL two_bytes_empty: got %b required 1", empty); end
    vectors++; if (overflow !== 1'b0)   begin miscompares++; $display("[TB] FAIL two_bytes_overflow: got %b required 0", overflow); end
    vectors++; if (pulses - base !== 2) begin miscompares++; $display("[TB] FAIL two_bytes_pulses: got %0d required 2", pulses - base); end
    vectors++; if (frame_err !== 0)     begin miscompares++; $display("[TB] FAIL two_bytes_framing: got %0d errors required 0", frame_err); end
    vectors++; if (tx_enable !== 1'b1)  begin miscompares++; $display("[TB] FAIL two_bytes_tx_enable: got %b required 1", tx_enable); end
  endtask

  task automatic test_overflow();
    int guard;
    logic [7:0] e;
    logic [7:0] g;
    do_reset();
    for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i), i < 16);
    vectors++; if (count !== 5'd16)    begin miscompares++; $display("[TB] FAIL overflow_count: got %0d required 16", count); end
    vectors++; if (full !== 1'b1)      begin miscompares++; $display("[TB] FAIL overflow_full: got %b required 1", full); end
    vectors++; if (overflow !== 1'b1)  begin miscompares++; $display("[TB] FAIL overflow_flag: got %b required 1", overflow); end
    en = 1'b1;
    guard = 0;
    while (rx_q.size() < 16 && guard < 600) begin @(negedge clk); guard++; end
    vectors++;
    if (rx_q.size() < 16) begin miscompares++; $display("[TB] FAIL overflow_frames: got %0d frames required 16", rx_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) g = rx_q.pop_front(); else g = 'x;
      vectors++;
      if (g !== e) begin miscompares++; $display("[TB] FAIL overflow_data: got %h required %h", g, e); end
    end
    repeat (30) @(negedge clk);
    vectors++; if (rx_q.size() !== 0) begin miscompares++; $display("[TB] FAIL overflow_17th_absent: got %0d extra frames required 0", rx_q.size()); end
    vectors++; if (empty !== 1'b1)    begin miscompares++; $display("[TB] FAIL overflow_drained_empty: got %b required 1", empty); end
  endtask

  task automatic test_timeout();
    int guard;
    do_reset();
    stuck_busy = 1'b1;
    push_byte(8'h77, 1'b0);
    push_byte(8'h88, 1'b0);
    en = 1'b1;
    guard = 0;
    while (tx_write !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    vectors++;
    if (tx_write !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_issue: got tx_write %b required 1", tx_write); end
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      vectors++;
      if (fault !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_early_fault: got %b required 0 at cycle %0d", fault, k); end
    end
    @(negedge clk);
    en = 1'b0;
    vectors++; if (fault !== 1'b1)      begin miscompares++; $display("[TB] FAIL timeout_fault: got %b required 1", fault); end
    vectors++; if (drain_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_idle: got %b required 0", drain_busy); end
    vectors++; if (count !== 5'd1)      begin miscompares++; $display("[TB] FAIL timeout_count: got %0d required 1", count); end
    stuck_busy = 1'b0;
  endtask

  task automatic test_en_drop();
    int guard;
    int base;
    logic [7:0] e;
    logic [7:0] g;
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'(8'hB0 + i), i > 0);
    en = 1'b1;
    guard = 0;
    while (tx_busy !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    vectors++;
    if (tx_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL en_drop_busy: got %b required 1", tx_busy); end
    @(negedge clk);
    vectors++; if (drain_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL en_drop_in_flight: got %b required 1", drain_busy); end
    en = 1'b0;
    base = pulses;
    repeat (12) @(negedge clk);
    vectors++; if (pulses !== base)     begin miscompares++; $display("[TB] FAIL en_drop_no_write: got %0d pulses required 0", pulses - base); end
    vectors++; if (count !== 5'd3)      begin miscompares++; $display("[TB] FAIL en_drop_count: got %0d required 3", count); end
    vectors++; if (drain_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL en_drop_idle: got %b required 0", drain_busy); end
    vectors++; if (rx_q.size() !== 0)   begin miscompares++; $display("[TB] FAIL en_drop_abandoned: got %0d frames required 0", rx_q.size()); end
    en = 1'b1;
    guard = 0;
    while (rx_q.size() < 3 && guard < 200) begin @(negedge clk); guard++; end
    vectors++;
    if (rx_q.size() < 3) begin miscompares++; $display("[TB] FAIL en_drop_frames: got %0d frames required 3", rx_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) g = rx_q.pop_front(); else g = 'x;
      vectors++;
      if (g !== e) begin miscompares++; $display("[TB] FAIL en_drop_data: got %h required %h", g, e); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i), 1'b0);
    vectors++; if (count !== 5'd5) begin miscompares++; $display("[TB] FAIL flush_precount: got %0d required 5", count); end
    flush = 1'b1;
    wr = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    flush = 1'b0;
    wr = 1'b0;
    vectors++; if (count !== 5'd0)     begin miscompares++; $display("[TB] FAIL flush_count: got %0d required 0", count); end
    vectors++; if (empty !== 1'b1)     begin miscompares++; $display("[TB] FAIL flush_empty: got %b required 1", empty); end
    vectors++; if (overflow !== 1'b0)  begin miscompares++; $display("[TB] FAIL flush_overflow: got %b required 0", overflow); end
    @(negedge clk);
    vectors++; if (count !== 5'd0)     begin miscompares++; $display("[TB] FAIL flush_push_dropped: got %0d required 0", count); end
  endtask

  task automatic test_reset_mid();
    int guard;
    int base;
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'(8'hC1 + i), 1'b0);
    base = pulses;
    en = 1'b1;
    guard = 0;
    while (pulses < base + 2 && guard < 200) begin @(negedge clk); guard++; end
    vectors++;
    if (pulses < base + 2) begin miscompares++; $display("[TB] FAIL reset_mid_second_byte: got %0d pulses required 2", pulses - base); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (count !== 5'd0)      begin miscompares++; $display("[TB] FAIL reset_mid_count: got %0d required 0", count); end
    vectors++; if (empty !== 1'b1)      begin miscompares++; $display("[TB] FAIL reset_mid_empty: got %b required 1", empty); end
    vectors++; if (full !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_mid_full: got %b required 0", full); end
    vectors++; if (tx_write !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_mid_tx_write: got %b required 0", tx_write); end
    vectors++; if (tx_data !== 8'h00)   begin miscompares++; $display("[TB] FAIL reset_mid_tx_data: got %h required 00", tx_data); end
    vectors++; if (tx_enable !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_mid_tx_enable: got %b required 0", tx_enable); end
    vectors++; if (drain_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_drain_busy: got %b required 0", drain_busy); end
    vectors++; if (fault !== 1'b0)      begin miscompares++; $display("[TB] FAIL reset_mid_fault: got %b required 0", fault); end
    vectors++; if (overflow !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_mid_overflow: got %b required 0", overflow); end
    base = pulses;
    repeat (40) @(negedge clk);
    vectors++; if (pulses !== base) begin miscompares++; $display("[TB] FAIL reset_mid_no_write: got %0d pulses required 0", pulses - base); end
    en = 1'b0;
  endtask

  initial begin
    $display("[TB] starting uart_tx_feeder bench");
    test_reset();
    test_two_bytes();
    test_overflow();
    test_timeout();
    test_en_drop();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
